// File: rtl/ps_setpoint_scheduler_pkg.sv
// Shared definitions for the setpoint scheduler.
//   - FSM state encoding, exported on the debug state port.
//   - Bit offsets of the fields in the 32-bit status word.
package ps_setpoint_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  // status = {overrunCount[15:0], frameCount[7:0], 6'b0, commitPending, busy}
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_COMMIT_BIT  = 1;
  localparam int STATUS_FRAME_LSB   = 8;
  localparam int STATUS_FRAME_W     = 8;
  localparam int STATUS_OVERRUN_LSB = 16;
  localparam int STATUS_OVERRUN_W   = 16;

endpackage

// File: rtl/ps_setpoint_table_ram.sv
// Simple dual-port setpoint table: one write port, one registered read port.
// The address MSB is the bank bit. Each bank is padded to a power of two so
// that the bank bit can sit directly above the word index.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only;
//                     the storage array itself is never cleared)
//   wr_en/addr/data   write port
//   rd_en/addr        read request; rd_data updates on the next rising edge
//   rd_data           registered read data, held while rd_en is low
module ps_setpoint_table_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Holding rd_data when no read is requested keeps the stream word stable
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ps_setpoint_scheduler.sv
// Double-buffered setpoint scheduler. Software fills the shadow bank and
// requests a commit; each accepted fofbTrigger optionally swaps banks and
// then streams the active bank out on an AXI-Stream-style port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     frames start only while high
//   fofbTrigger                one-cycle frame request
//   wrStrobe/wrAddress/wrData  shadow-bank write
//   commitStrobe               request a bank swap at the next frame start
//   SETPOINT_AXIS_*            setpoint stream
//   status                     {overrun[15:0], frames[7:0], 6'b0, commitPending, busy}
//   state_dbg                  current FSM state
// Handshake: a word transfers on a rising edge where TVALID and TREADY are
// both high; once TVALID rises, TDATA/TLAST hold until that transfer.
module ps_setpoint_scheduler
  import ps_setpoint_scheduler_pkg::*;
#(
  parameter int SETPOINT_COUNT = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              fofbTrigger,
  input  logic                              wrStrobe,
  input  logic [$clog2(SETPOINT_COUNT)-1:0] wrAddress,
  input  logic [DATA_WIDTH-1:0]             wrData,
  input  logic                              commitStrobe,
  output logic                              SETPOINT_AXIS_TVALID,
  output logic                              SETPOINT_AXIS_TLAST,
  input  logic                              SETPOINT_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]             SETPOINT_AXIS_TDATA,
  output logic [31:0]                       status,
  output logic [1:0]                        state_dbg
);

  localparam int IDX_W = $clog2(SETPOINT_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETPOINT_COUNT - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             active_bank;
  logic             commit_pending;
  logic [15:0]      overrun_count;
  logic [7:0]       frame_count;

  logic accept;
  logic handshake;
  logic last_word;
  logic swap;

  assign accept    = fofbTrigger && enable && (state == ST_IDLE);
  assign handshake = (state == ST_SEND) && SETPOINT_AXIS_TREADY;
  assign last_word = (idx == LAST_IDX);
  // A commit arriving in the same cycle as the accepted trigger joins the swap.
  assign swap      = accept && (commit_pending || commitStrobe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      overrun_count  <= '0;
      frame_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_FETCH;
            idx   <= '0;
          end
        end
        ST_FETCH: state <= ST_SEND;
        ST_SEND: begin
          if (handshake) begin
            if (last_word) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_FETCH;
              idx   <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (swap) begin
        active_bank <= ~active_bank;
      end

      if (accept) begin
        commit_pending <= 1'b0;
      end else if (commitStrobe) begin
        commit_pending <= 1'b1;
      end

      if (fofbTrigger && (state != ST_IDLE) && (overrun_count != 16'hFFFF)) begin
        overrun_count <= overrun_count + 16'd1;
      end

      if (handshake && last_word) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Writes always target the bank that is not being streamed, so a write
  // during a frame never changes that frame's data.
  ps_setpoint_table_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IDX_W + 1)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wrStrobe),
    .wr_addr ({~active_bank, wrAddress}),
    .wr_data (wrData),
    .rd_en   (state == ST_FETCH),
    .rd_addr ({active_bank, idx}),
    .rd_data (SETPOINT_AXIS_TDATA)
  );

  assign SETPOINT_AXIS_TVALID = (state == ST_SEND);
  assign SETPOINT_AXIS_TLAST  = (state == ST_SEND) && last_word;
  assign state_dbg            = state;

  always_comb begin
    status = '0;
    status[STATUS_BUSY_BIT]                              = (state != ST_IDLE);
    status[STATUS_COMMIT_BIT]                            = commit_pending;
    status[STATUS_FRAME_LSB +: STATUS_FRAME_W]           = frame_count;
    status[STATUS_OVERRUN_LSB +: STATUS_OVERRUN_W]       = overrun_count;
  end

endmodule

// File: tb/tb_ps_setpoint_scheduler.sv
module tb_ps_setpoint_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable;
  logic          trig;
  logic          wr;
  logic [1:0]    waddr;
  logic [DW-1:0] wdata;
  logic          commit;
  logic          tready;
  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic [31:0]   status;
  logic [1:0]    state_dbg;

  ps_setpoint_scheduler #(.SETPOINT_COUNT(N), .DATA_WIDTH(DW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable               (enable),
    .fofbTrigger          (trig),
    .wrStrobe             (wr),
    .wrAddress            (waddr),
    .wrData               (wdata),
    .commitStrobe         (commit),
    .SETPOINT_AXIS_TVALID (tvalid),
    .SETPOINT_AXIS_TLAST  (tlast),
    .SETPOINT_AXIS_TREADY (tready),
    .SETPOINT_AXIS_TDATA  (tdata),
    .status               (status),
    .state_dbg            (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: an accepted trigger snapshots the active bank into the
  // expected queue; each word becomes presentable two edges after the
  // previous transfer (or after the trigger).
  logic [DW-1:0] m_bank [0:1][0:N-1];
  logic          m_act, m_pend, m_busy;
  int            m_left;
  longint        m_cyc, m_valid_cyc;
  int unsigned   m_over, m_frames;

  task automatic model_reset();
    exp_q.delete();
    m_act = 0; m_pend = 0; m_busy = 0; m_left = 0;
    m_valid_cyc = 0; m_over = 0; m_frames = 0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = {m_over[15:0], m_frames[7:0], 6'b0, m_pend, m_busy};
    return s;
  endfunction

  task automatic model_edge();
    logic busy_pre;
    logic acc;
    logic [W-1:0] w;
    m_cyc++;
    if (!rst_n) return;
    if (wr) m_bank[~m_act][waddr] = wdata;
    busy_pre = m_busy;
    if (m_busy && m_cyc >= m_valid_cyc && tready) begin
      m_left--;
      m_valid_cyc = m_cyc + 2;
      if (m_left == 0) begin
        m_busy = 0;
        m_frames++;
      end
    end
    if (trig && busy_pre && m_over < 65535) m_over++;
    acc = trig && !busy_pre && enable;
    if (acc) begin
      if (m_pend || commit) m_act = ~m_act;
      m_pend = 0;
      for (int i = 0; i < N; i++) begin
        w = {(i == N - 1) ? 1'b1 : 1'b0, m_bank[m_act][i]};
        exp_q.push_back(w);
      end
      m_busy = 1;
      m_left = N;
      m_valid_cyc = m_cyc + 2;
    end else if (commit) begin
      m_pend = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_pulses();
    trig = 0; wr = 0; commit = 0;
  endtask

  task automatic write_word(input logic [1:0] a, input logic [DW-1:0] d);
    wr = 1; waddr = a; wdata = d;
    tick();
    clear_pulses();
  endtask

  task automatic pulse_trigger(input logic with_commit);
    trig = 1; commit = with_commit;
    tick();
    clear_pulses();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tlast"},  tlast,  0);
    check({tag, "_tdata"},  tdata,  0);
    check({tag, "_status"}, status, 0);
  endtask

  // ---------------- monitor ----------------
  logic          stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      check("tvalid", tvalid, m_busy && (m_cyc + 1 >= m_valid_cyc));
      check("status", status, exp_status());
      check("busy_vs_state", state_dbg != 2'd0, m_busy);
      if (stall_prev) begin
        check("stall_tdata", tdata, prev_data);
        check("stall_tlast", tlast, prev_last);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at t=%0t", tdata, $time);
        end else begin
          check("tdata", tdata, exp_q[0][DW-1:0]);
          check("tlast", tlast, exp_q[0][DW]);
          void'(exp_q.pop_front());
        end
      end
      stall_prev <= tvalid && !tready;
      prev_data  <= tdata;
      prev_last  <= tlast;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) m_bank[b][i] = '0;
    m_cyc = 0;
    model_reset();
    rst_n = 0; enable = 0; tready = 1; waddr = 0; wdata = 0;
    clear_pulses();
    #3;
    check_reset_outputs("reset");
    ticks(2);
    rst_n = 1;
    enable = 1;
    ticks(2);

    // Basic frame from a freshly committed shadow bank.
    for (int i = 0; i < N; i++) write_word(2'(i), 32'h10 + 32'(i));
    commit = 1; tick(); clear_pulses();
    pulse_trigger(0);
    ticks(10);
    check("frame_count_after_first", status[15:8], 8'd1);

    // Fill the other bank so every bank streamed later holds known data.
    for (int i = 0; i < N; i++) write_word(2'(i), $urandom);

    // Consumer stall on word 1.
    pulse_trigger(1);
    ticks(2);
    tready = 0;
    ticks(5);
    tready = 1;
    ticks(10);

    // Trigger while busy is dropped and counted.
    pulse_trigger(0);
    ticks(2);
    pulse_trigger(0);
    ticks(10);

    // Mid-frame write and commit affect only the next frame.
    pulse_trigger(0);
    ticks(1);
    wr = 1; waddr = 2; wdata = 32'hAA; commit = 1;
    tick();
    clear_pulses();
    ticks(8);
    check("pending_after_midframe_commit", status[1], 1'b1);
    pulse_trigger(0);
    ticks(10);

    // enable low: trigger ignored, nothing counted.
    enable = 0;
    pulse_trigger(0);
    ticks(5);
    enable = 1;

    // Asynchronous reset in the middle of a frame.
    pulse_trigger(0);
    ticks(2);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midframe_reset");
    model_reset();
    ticks(2);
    rst_n = 1;
    ticks(1);
    pulse_trigger(0);
    ticks(10);

    // Overrun counter saturation while the stream is stalled.
    tready = 0;
    pulse_trigger(0);
    trig = 1;
    ticks(65537);
    trig = 0;
    check("overrun_saturated", status[31:16], 16'hFFFF);
    tready = 1;
    ticks(10);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      wr     = ($urandom_range(0, 9) < 3);
      waddr  = 2'($urandom_range(0, N - 1));
      wdata  = $urandom;
      commit = ($urandom_range(0, 9) == 0);
      trig   = ($urandom_range(0, 99) < 15);
      enable = ($urandom_range(0, 9) < 8);
      tready = ($urandom_range(0, 9) < 7);
      tick();
    end
    clear_pulses();
    enable = 1;
    tready = 1;

    // Drain with a bounded wait.
    for (int c = 0; c < 50 && m_busy; c++) tick();
    if (m_busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got busy expected idle at t=%0t", $time);
    end
    ticks(2);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps_setpoint_scheduler.md
PS_SETPOINT_SCHEDULER -- requirements
Module: ps_setpoint_scheduler

Interface
REQ-001 Parameter SETPOINT_COUNT, default 8, number of setpoints per frame; SHALL be 2..1024.
REQ-002 Parameter DATA_WIDTH, default 32, setpoint word width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  frames start only while high.
REQ-006 fofbTrigger  input  1  one-cycle pulse requesting one setpoint frame.
REQ-007 wrStrobe  input  1  write wrData to the shadow bank at wrAddress.
REQ-008 wrAddress  input  clog2(SETPOINT_COUNT)  shadow-bank word index.
REQ-009 wrData  input  DATA_WIDTH  setpoint value.
REQ-010 commitStrobe  input  1  request shadow/active bank swap.
REQ-011 SETPOINT_AXIS_TVALID / TLAST  output  1 each  stream valid and last-word flag.
REQ-012 SETPOINT_AXIS_TREADY  input  1  downstream ready.
REQ-013 SETPOINT_AXIS_TDATA  output  DATA_WIDTH  setpoint word.
REQ-014 status  output  32  {overrunCount[15:0], frameCount[7:0], 6'b0, commitPending, busy}.

Function
REQ-015 Table SHALL hold two banks of SETPOINT_COUNT words; activeBank selects the streamed bank, writes go only to the other bank.
REQ-016 commitStrobe SHALL set commitPending; the swap SHALL occur only on the cycle a trigger is accepted, before the frame's first read, then clear commitPending.
REQ-017 commitStrobe coincident with trigger acceptance SHALL be included in that swap.
REQ-018 FSM states IDLE, FETCH, SEND; IDLE->FETCH on accepted trigger; FETCH->SEND after one cycle (RAM read latency 1); SEND->FETCH on handshake with index < SETPOINT_COUNT-1; SEND->IDLE on handshake of last word.
REQ-019 Trigger accepted only when state IDLE and enable high; first TVALID SHALL assert 2 cycles after the trigger cycle.
REQ-020 TVALID SHALL be high only in SEND; TDATA and TLAST SHALL be stable while TVALID high and TREADY low.
REQ-021 Words SHALL be emitted in index order 0..SETPOINT_COUNT-1; TLAST high only on index SETPOINT_COUNT-1.
REQ-022 Throughput with TREADY held high: one word per 2 cycles.
REQ-023 Trigger while not IDLE SHALL be dropped and increment overrunCount, saturating at 0xFFFF.
REQ-024 Trigger while enable low and IDLE SHALL be ignored with no count.
REQ-025 enable deasserting mid-frame SHALL NOT abort the frame.
REQ-026 frameCount SHALL increment (wrapping mod 256) on the last-word handshake.
REQ-027 busy SHALL be high whenever state is not IDLE.
REQ-028 wrStrobe writes are never blocked; a write during a frame SHALL NOT alter that frame's data.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, TVALID/TLAST 0, TDATA 0, activeBank 0, commitPending 0, overrunCount 0, frameCount 0, busy 0.
REQ-030 Reset mid-frame SHALL abort the frame with no TLAST; table RAM contents are not reset.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and status field bit offsets.
REQ-032 One sub-module, ps_setpoint_table_ram: simple dual-port RAM, depth 2*SETPOINT_COUNT, registered read, bank bit as address MSB.

Verification
REQ-033 SETPOINT_COUNT=4; write shadow 0x10..0x13, commit, trigger, TREADY=1 -> TDATA 0x10,0x11,0x12,0x13 on cycles T+2,+4,+6,+8, TLAST on 0x13, frameCount=1.
REQ-034 Hold TREADY low 5 cycles on word 1 -> TDATA/TLAST stable, no word skipped or repeated.
REQ-035 Second trigger at T+3 -> dropped, overrunCount=1, frame unaffected; 65537 overruns -> overrunCount=0xFFFF.
REQ-036 Mid-frame write 0xAA to shadow index 2 plus commit -> current frame unchanged, commitPending=1; next frame emits 0xAA at index 2.
REQ-037 rst_n low during SEND -> TVALID low same cycle, status=0; post-reset trigger streams bank 0.
REQ-038 enable low plus trigger -> no TVALID, overrunCount unchanged.
